// File: rtl/snake_head_stepper.sv
// rtl/snake_head_stepper.sv - snake head stepper: move-tick divider and IDLE/RUN/DEAD game FSM
// Advances the head one cell per tick, refuses 180-degree turns, stops at the walls.
module snake_head_stepper #(
  parameter int         GRID_W    = 32,
  parameter int         GRID_H    = 24,
  parameter int         TICK_DIV  = 25_000_000,
  parameter int         START_X   = 16,
  parameter int         START_Y   = 12,
  parameter logic [3:0] START_DIR = 4'b0001,
  localparam int        XW        = $clog2(GRID_W),
  localparam int        YW        = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    direction,
  input  logic          start,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [3:0]    cur_dir,
  output logic          step,
  output logic          collision,
  output logic          running
);

  localparam int CW = $clog2(TICK_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DEAD = 2'd2
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [XW-1:0] head_x_q;
  logic [YW-1:0] head_y_q;
  logic [3:0]    cur_dir_q;
  logic          step_q;
  logic          collision_q;
  logic          running_q;
  logic          start_q;

  logic          tick_d;
  logic          dir_ok_d;
  logic [3:0]    opp_dir_d;
  logic [3:0]    new_dir_d;
  logic [XW:0]   next_x_d;
  logic [YW:0]   next_y_d;
  logic          hit_wall_d;

  always_comb begin
    tick_d    = (state_q == S_RUN) && (cnt_q == CW'(TICK_DIV - 1));
    dir_ok_d  = 1'b0;
    case (direction)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: dir_ok_d = 1'b1;
      default:                            dir_ok_d = 1'b0;
    endcase
    // Swapping the up/down and left/right bit pairs yields the reverse heading.
    opp_dir_d = {cur_dir_q[2], cur_dir_q[3], cur_dir_q[0], cur_dir_q[1]};
    new_dir_d = (dir_ok_d && (direction != opp_dir_d)) ? direction : cur_dir_q;
    next_x_d  = {1'b0, head_x_q};
    next_y_d  = {1'b0, head_y_q};
    case (new_dir_d)
      4'b1000: next_y_d = {1'b0, head_y_q} - (YW+1)'(1);
      4'b0100: next_y_d = {1'b0, head_y_q} + (YW+1)'(1);
      4'b0010: next_x_d = {1'b0, head_x_q} - (XW+1)'(1);
      default: next_x_d = {1'b0, head_x_q} + (XW+1)'(1);
    endcase
    // Underflow wraps to all-ones in the widened value, so one compare catches both walls.
    hit_wall_d = (next_x_d >= (XW+1)'(GRID_W)) || (next_y_d >= (YW+1)'(GRID_H));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      head_x_q    <= XW'(START_X);
      head_y_q    <= YW'(START_Y);
      cur_dir_q   <= START_DIR;
      step_q      <= 1'b0;
      collision_q <= 1'b0;
      running_q   <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      step_q  <= 1'b0;
      start_q <= start;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            cnt_q     <= '0;
          end
        end
        S_RUN: begin
          if (tick_d) begin
            cnt_q     <= '0;
            cur_dir_q <= new_dir_d;
            if (hit_wall_d) begin
              state_q     <= S_DEAD;
              running_q   <= 1'b0;
              collision_q <= 1'b1;
            end else begin
              head_x_q <= next_x_d[XW-1:0];
              head_y_q <= next_y_d[YW-1:0];
              step_q   <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DEAD: begin
          // Only a fresh press restarts; a level held through death is ignored.
          if (start && !start_q) begin
            state_q     <= S_IDLE;
            collision_q <= 1'b0;
            head_x_q    <= XW'(START_X);
            head_y_q    <= YW'(START_Y);
            cur_dir_q   <= START_DIR;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          running_q   <= 1'b0;
          collision_q <= 1'b0;
          cnt_q       <= '0;
        end
      endcase
    end
  end

  assign head_x    = head_x_q;
  assign head_y    = head_y_q;
  assign cur_dir   = cur_dir_q;
  assign step      = step_q;
  assign collision = collision_q;
  assign running   = running_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// tb/tb_snake_head_stepper.sv - randomized bench for snake_head_stepper against a grid-arithmetic model
module tb_snake_head_stepper;

  localparam int TD = 4;
  localparam int GW = 32;
  localparam int GH = 24;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] direction = 4'b0001;
  logic       start = 1'b0;
  logic [4:0] head_x;
  logic [4:0] head_y;
  logic [3:0] cur_dir;
  logic       step;
  logic       collision;
  logic       running;

  int vectors = 0;
  int miscompares = 0;

  // Model state: mode 0 idle, 1 running, 2 dead.
  int         m_mode = 0;
  int         m_x = 16;
  int         m_y = 12;
  logic [3:0] m_dir = 4'b0001;
  int         m_cnt = 0;
  bit         m_step = 0;
  bit         m_prev = 0;

  snake_head_stepper #(
    .GRID_W(GW), .GRID_H(GH), .TICK_DIV(TD),
    .START_X(16), .START_Y(12), .START_DIR(4'b0001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .direction(direction), .start(start),
    .head_x(head_x), .head_y(head_y), .cur_dir(cur_dir),
    .step(step), .collision(collision), .running(running)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic dir_vec(input logic [3:0] d, output int dx, output int dy);
    dx = 0;
    dy = 0;
    if (d == 4'b1000) dy = -1;
    else if (d == 4'b0100) dy = 1;
    else if (d == 4'b0010) dx = -1;
    else if (d == 4'b0001) dx = 1;
  endtask

  task automatic model_step();
    int dxn, dyn, dxc, dyc, nx, ny;
    logic [3:0] nd;
    if (!rst_n) begin
      m_mode = 0; m_x = 16; m_y = 12; m_dir = 4'b0001;
      m_cnt = 0; m_step = 0; m_prev = 0;
    end else begin
      m_step = 0;
      if (m_mode == 0) begin
        if (start) begin
          m_mode = 1;
          m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        if (m_cnt == TD - 1) begin
          m_cnt = 0;
          nd = m_dir;
          if (direction inside {4'b1000, 4'b0100, 4'b0010, 4'b0001}) begin
            dir_vec(direction, dxn, dyn);
            dir_vec(m_dir, dxc, dyc);
            if (!(dxn == -dxc && dyn == -dyc)) nd = direction;
          end
          dir_vec(nd, dxn, dyn);
          nx = m_x + dxn;
          ny = m_y + dyn;
          m_dir = nd;
          if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
            m_mode = 2;
          end else begin
            m_x = nx;
            m_y = ny;
            m_step = 1;
          end
        end else begin
          m_cnt++;
        end
      end else begin
        if (start && !m_prev) begin
          m_mode = 0; m_x = 16; m_y = 12; m_dir = 4'b0001;
        end
      end
      m_prev = start;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_eq("head_x", head_x, m_x);
    check_eq("head_y", head_y, m_y);
    check_eq("cur_dir", cur_dir, m_dir);
    check_eq("step", step, m_step);
    check_eq("collision", collision, m_mode == 2);
    check_eq("running", running, m_mode == 1);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    // Reset values
    rst_n = 1'b0; start = 1'b0; direction = 4'b0001;
    run(2);
    check_eq("rst_x", head_x, 16);
    check_eq("rst_y", head_y, 12);
    check_eq("rst_dir", cur_dir, 4'b0001);
    check_eq("rst_run", running, 0);

    // Straight right, reversal ignored, then turn up
    rst_n = 1'b1; start = 1'b1;
    run(9);
    check_eq("x_after_2_ticks", head_x, 18);
    direction = 4'b0010;
    run(8);
    check_eq("reversal_ignored_x", head_x, 20);
    direction = 4'b1000;
    run(4);
    check_eq("turn_up_y", head_y, 11);
    check_eq("turn_up_dir", cur_dir, 4'b1000);
    direction = 4'b1100;
    run(4);
    direction = 4'b0000;
    run(4);
    check_eq("invalid_dir_y", head_y, 9);
    check_eq("invalid_dir_dir", cur_dir, 4'b1000);

    // Right wall: 11 legal steps to x=31, then the fatal tick
    direction = 4'b0001;
    run(44);
    check_eq("at_right_edge", head_x, 31);
    run(4);
    check_eq("wall_x_hold", head_x, 31);
    check_eq("wall_collision", collision, 1);
    check_eq("wall_running", running, 0);
    run(6);
    check_eq("held_start_dead", collision, 1);

    // Restart, then hit the top wall
    start = 1'b0; run(1);
    start = 1'b1; run(1);
    check_eq("restart_x", head_x, 16);
    check_eq("restart_y", head_y, 12);
    check_eq("restart_dir", cur_dir, 4'b0001);
    direction = 4'b1000;
    run(60);
    check_eq("top_y", head_y, 0);
    check_eq("top_collision", collision, 1);
    run(4);
    check_eq("top_held_start", collision, 1);
    start = 1'b0; run(1);
    start = 1'b1; run(1);
    check_eq("restart2_y", head_y, 12);

    // Reset landing on a tick cycle
    direction = 4'b0001;
    for (int i = 0; i < 8 && !(m_mode == 1 && m_cnt == TD - 1); i++) cycle();
    rst_n = 1'b0;
    cycle();
    check_eq("rst_tick_step", step, 0);
    check_eq("rst_tick_x", head_x, 16);
    check_eq("rst_tick_running", running, 0);
    rst_n = 1'b1;

    // Randomized play
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 4) start = ~start;
      if ($urandom_range(0, 9) < 8) direction = 4'(4'b0001 << $urandom_range(0, 3));
      else direction = 4'($urandom);
      rst_n = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
